sseg_display_arbiter: RTL

SSEG_DISPLAY_ARBITER -- requirements
Module: sseg_display_arbiter

---
 rtl/sseg_display_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/sseg_display_arbiter.sv
// Round-robin arbiter that lets several requesters share one seven-segment
// display. A granted word stays on data_out for a dwell window of DWELL_CLKS
// cycles; the owner may refresh its word mid-window, and everyone else waits
// until the window expires.
//
// Handshake: a requester offers a word by raising its req_valid_in bit; the
// word transfers on a cycle where both req_valid_in[i] and req_ready_out[i]
// are high. Ready is combinational, one-hot or zero, never raised for a
// requester whose valid is low, and valid may be dropped before ready with no
// transfer taking place.
module sseg_display_arbiter #(
    parameter int REQUESTERS = 4,
    parameter int WIDTH      = 32,
    parameter int CLK_PERIOD = 10,
    parameter int DWELL_US   = 500000,
    localparam int OW         = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1,
    localparam int DWELL_CLKS = DWELL_US * 1000 / CLK_PERIOD,
    localparam int CW         = $clog2(DWELL_CLKS) + 1
) (
    input  logic                        clk_in,
    input  logic                        rst_low_in,
    input  logic [REQUESTERS-1:0]       req_valid_in,
    input  logic [REQUESTERS*WIDTH-1:0] req_data_in,
    output logic [REQUESTERS-1:0]       req_ready_out,
    output logic [WIDTH-1:0]            data_out,
    output logic [OW-1:0]               owner_out,
    output logic                        active_out,
    output logic                        state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(DWELL_CLKS - 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [OW-1:0]   ptr;

    logic            any_valid;
    logic            at_last;
    logic            grant;
    logic            update;
    logic [OW-1:0]   winner;
    logic [OW-1:0]   next_ptr;
    logic [WIDTH-1:0] winner_word;
    logic [WIDTH-1:0] owner_word;

    assign any_valid   = |req_valid_in;
    assign at_last     = (cnt == LAST);
    assign grant       = rst_low_in && any_valid && ((state == IDLE) || at_last);
    assign update      = rst_low_in && (state == SHOW) && !at_last && req_valid_in[owner_out];
    assign winner_word = req_data_in[WIDTH*int'(winner) +: WIDTH];
    assign owner_word  = req_data_in[WIDTH*int'(owner_out) +: WIDTH];
    assign active_out  = (state == SHOW);
    assign state_dbg   = state;

    // First valid requester found searching upward from ptr, wrapping around.
    always_comb begin
        logic found;
        int   idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < REQUESTERS; k++) begin
            idx = (int'(ptr) + k) % REQUESTERS;
            if (!found && req_valid_in[idx]) begin
                found  = 1'b1;
                winner = OW'(idx);
            end
        end
    end

    // Pointer moves to the slot after the winner, wrapping at REQUESTERS.
    always_comb begin
        if (winner == OW'(REQUESTERS - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = winner + 1'b1;
        end
    end

    // Ready goes to the grant winner, or to the owner refreshing mid-window.
    always_comb begin
        req_ready_out = '0;
        if (grant) begin
            req_ready_out[winner] = 1'b1;
        end else if (update) begin
            req_ready_out[owner_out] = 1'b1;
        end
    end

    // Window FSM: grant opens a fresh window; expiry with nobody waiting idles.
    always_ff @(posedge clk_in or negedge rst_low_in) begin
        if (!rst_low_in) begin
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= '0;
            data_out  <= '0;
            owner_out <= '0;
        end else if (grant) begin
            state     <= SHOW;
            cnt       <= '0;
            ptr       <= next_ptr;
            data_out  <= winner_word;
            owner_out <= winner;
        end else if (state == SHOW) begin
            if (at_last) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
                if (update) begin
                    data_out <= owner_word;
                end
            end
        end
    end

endmodule
